// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus bundle: I-cache request/response, decode handshake and redirect input.
interface fetch_sequencer_if;
    logic        ICACHE_ren;
    logic [29:0] ICACHE_addr;
    logic [31:0] ICACHE_rdata;
    logic        ICACHE_stall;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redir_valid;
    logic [31:0] redir_base;
    logic [31:0] redir_imm;
    logic        redir_jalr;
    logic        misalign_err;

    modport master (
        output ICACHE_ren, ICACHE_addr, instr_valid, instr, instr_pc, misalign_err,
        input  ICACHE_rdata, ICACHE_stall, instr_ready,
        input  redir_valid, redir_base, redir_imm, redir_jalr
    );

    modport slave (
        input  ICACHE_ren, ICACHE_addr, instr_valid, instr, instr_pc, misalign_err,
        output ICACHE_rdata, ICACHE_stall, instr_ready,
        output redir_valid, redir_base, redir_imm, redir_jalr
    );
endinterface

// File: rtl/fetch_sequencer.sv
// PC/fetch controller: issues word reads to the I-cache and presents each fetched
// instruction to decode on valid/ready; handles branch/JAL/JALR redirects.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    fetch_sequencer_if.master bus
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_VALID, S_HALT} state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;
    logic [31:0] r_pend_target;
    logic        r_pend_valid;
    logic        r_ren;
    logic        r_instr_valid;
    logic        r_misalign;

    logic [31:0] w_sum;
    logic [31:0] w_target;
    logic        w_misaligned;
    logic        w_redir_err;

    always_comb begin
        w_sum        = bus.redir_base + bus.redir_imm;
        w_target     = {w_sum[31:1], w_sum[0] & ~bus.redir_jalr};
        w_misaligned = w_target[1] | (w_target[0] & ~bus.redir_jalr);
        w_redir_err  = bus.redir_valid & w_misaligned & (r_state != S_HALT);
    end

    assign bus.ICACHE_ren   = r_ren;
    assign bus.ICACHE_addr  = r_pc[31:2];
    assign bus.instr_valid  = r_instr_valid;
    assign bus.instr        = r_instr;
    assign bus.instr_pc     = r_instr_pc;
    assign bus.misalign_err = r_misalign;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_pend_target <= '0;
            r_pend_valid  <= 1'b0;
            r_ren         <= 1'b0;
            r_instr_valid <= 1'b0;
            r_misalign    <= 1'b0;
        end else begin
            r_misalign <= 1'b0;
            // A misaligned redirect overrides every state action, including a stalled request.
            if (w_redir_err) begin
                r_state       <= S_HALT;
                r_ren         <= 1'b0;
                r_instr_valid <= 1'b0;
                r_pend_valid  <= 1'b0;
                r_misalign    <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_REQ;
                        r_ren   <= 1'b1;
                    end
                    S_REQ: begin
                        if (bus.ICACHE_stall) begin
                            // Address must stay stable while stalled; park the redirect.
                            if (bus.redir_valid) begin
                                r_pend_target <= w_target;
                                r_pend_valid  <= 1'b1;
                            end
                        end else if (bus.redir_valid || r_pend_valid) begin
                            r_pc         <= bus.redir_valid ? w_target : r_pend_target;
                            r_pend_valid <= 1'b0;
                        end else begin
                            r_instr       <= bus.ICACHE_rdata;
                            r_instr_pc    <= r_pc;
                            r_pc          <= r_pc + 32'd4;
                            r_instr_valid <= 1'b1;
                            r_ren         <= 1'b0;
                            r_state       <= S_VALID;
                        end
                    end
                    S_VALID: begin
                        if (bus.redir_valid) begin
                            r_instr_valid <= 1'b0;
                            r_pc          <= w_target;
                            r_ren         <= 1'b1;
                            r_state       <= S_REQ;
                        end else if (bus.instr_ready) begin
                            r_instr_valid <= 1'b0;
                            r_ren         <= 1'b1;
                            r_state       <= S_REQ;
                        end
                    end
                    S_HALT: begin
                        r_ren         <= 1'b0;
                        r_instr_valid <= 1'b0;
                    end
                    default: begin
                        r_state       <= S_HALT;
                        r_ren         <= 1'b0;
                        r_instr_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
